logic_unit_arbiter: RTL
=======================

# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one `logic_unit` instance between `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake, drives the shared unit from registered operands, and returns a registered result to the granted requester only. Undefined opcodes are flagged. The block sits between client pipelines and the logic datapath, and replaces direct combinational hookups.

## Interface
- `DATA_WIDTH`, 8, operand/result width; passed to the internal `logic_unit`
- `NUM_REQ`, 4, number of requesters (2..8)
- `clk` input 1, single clock; all state updates on rising edge
- `rst_n` input 1, asynchronous active-low reset
- `req_valid` input NUM_REQ, per-requester request valid
- `req_ready` output NUM_REQ, one-hot acceptance strobe
- `req_a` input NUM_REQ*DATA_WIDTH, packed operand A; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
- `req_b` input NUM_REQ*DATA_WIDTH, packed operand B; same slicing as `req_a`
- `req_op` input NUM_REQ*3, packed opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT(a), 4 NAND, 5 NOR, 6 XNOR
- `rsp_valid` output NUM_REQ, one-hot response valid
- `rsp_ready` input NUM_REQ, per-requester response accept
- `rsp_data` output DATA_WIDTH, registered result
- `rsp_err` output 1, high with `rsp_valid` when the opcode was 3'b111
- `busy` output 1, high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - The winner is the first requester with `req_valid` high, searching from `rr_ptr` upward and wrapping at NUM_REQ-1 to 0.
  - `req_ready[winner]` is asserted combinationally in the same cycle. All other `req_ready` bits stay 0.
  - At the clock edge: latch the winner's a, b and op, and the grant index. Go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC**
  - Latched operands drive the internal `logic_unit`.
  - At the edge: `rsp_data` <= unit result, and `rsp_err` <= (op == 3'b111).
  - For op 3'b111, `rsp_data` <= 0 regardless of the unit output. Go to RESP.
- **RESP**
  - `rsp_valid[grant]` is high.
  - When `rsp_ready[grant]` is high at an edge: `rr_ptr` <= (grant+1) mod NUM_REQ, and go to IDLE.
  - Otherwise hold `rsp_data`, `rsp_err` and `rsp_valid` stable.
- `rsp_ready` bits of non-granted requesters are ignored.
- Requests are not accepted outside IDLE. `req_ready` is 0 in EXEC and RESP.
- Inputs may change after acceptance without affecting the result, because operands are latched.
- A requester may hold `req_valid` through its own response. It becomes eligible again in the IDLE that follows.
- The pointer wraps modulo NUM_REQ. If NUM_REQ is not a power of two, pointer values ≥ NUM_REQ are unreachable.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `busy` 0, latched operands 0.
- `req_ready` is 0 whenever `rst_n` is low.
- Latency, with acceptance at edge T:
  - EXEC during cycle T..T+1.
  - `rsp_valid` is high starting after edge T+1.
  - The earliest response handshake is at edge T+2.
- Minimum throughput: one operation per 3 cycles, when `rsp_ready` is held high.
- Back-to-back: after the RESP handshake edge, IDLE can accept in the next cycle.
- Simultaneous requests: exactly one is granted per IDLE cycle, and the others wait.
- Starvation bound: a continuously valid requester is served within NUM_REQ operations.
- Reset mid-operation (any state): return to reset values immediately (asynchronous). The in-flight response is discarded and is never presented.

## Test plan
- **Single request.** Requester 0 sends a=0xCC, b=0xAA, op=0.
  - `req_ready[0]` is high in the same cycle.
  - `rsp_valid[0]` goes high 2 edges later with `rsp_data`=0x88 and `rsp_err`=0. `busy` is high throughout.
- **All ops through one port.** With a=0xCC, b=0xAA, ops 0..6 must give 0x88, 0xEE, 0x66, 0x33, 0x77, 0x11, 0x99.
- **Round-robin fairness.** All 4 `req_valid` are held high and `rsp_ready` is all 1s.
  - Grants go 0, 1, 2, 3, 0, in that order.
  - Only the granted bit of `rsp_valid` is ever set. Ops complete every 3 cycles.
- **Backpressure.** `rsp_ready[1]` is held low for 5 cycles while requester 1 is granted.
  - `rsp_data`, `rsp_err` and `rsp_valid` stay stable, and `req_ready` stays 0.
  - Completion happens on the cycle `rsp_ready[1]` rises.
- **Undefined opcode.** Requester 2 sends op=3'b111 with a=0xFF.
  - The response has `rsp_err`=1 and `rsp_data`=0x00.
  - The next operation from the same port has `rsp_err`=0.
- **Reset mid-operation.** Drive `rst_n` low during RESP of requester 3.
  - All outputs go to 0 asynchronously, and `rr_ptr` returns to 0.
  - After release, with requesters 1 and 3 valid, requester 1 is granted first.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NUM_REQ requesters.
// One operation in flight; operands and result are registered.

module logic_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = a ^ b;
      3'd3:    y = ~a;
      3'd4:    y = ~(a & b);
      3'd5:    y = ~(a | b);
      3'd6:    y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

module logic_unit_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]          req_op,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         ptr_next;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [2:0]            op_code;
  logic [DATA_WIDTH-1:0] unit_y;

  logic                  win_found;
  logic [PW-1:0]         win_idx;
  logic [DATA_WIDTH-1:0] win_a;
  logic [DATA_WIDTH-1:0] win_b;
  logic [2:0]            win_op;

  logic_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_logic_unit (
    .a  (op_a),
    .b  (op_b),
    .op (op_code),
    .y  (unit_y)
  );

  // Search from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NUM_REQ;
      idx_w = PW'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  assign win_a  = req_a[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign win_b  = req_b[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign win_op = req_op[win_idx*3 +: 3];

  assign ptr_next = (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[grant]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && win_found && rst_n) req_ready[win_idx] = 1'b1;
    if (state == RESP) rsp_valid[grant] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant   <= win_idx;
            op_a    <= win_a;
            op_b    <= win_b;
            op_code <= win_op;
          end
        end
        EXEC: begin
          rsp_data <= (op_code == 3'b111) ? '0 : unit_y;
          rsp_err  <= (op_code == 3'b111);
        end
        RESP: begin
          if (rsp_ready[grant]) rr_ptr <= ptr_next;
        end
        default: ;
      endcase
    end
  end

endmodule
